tqvp_spi_target: RTL

SPI target (slave) peripheral for the TinyQV peripheral bus: an external SPI controller clocks bytes in and out over a PMOD; the CPU exchanges those bytes through memory-mapped registers. Supports SPI mode 0 only (CPOL=0, CPHA=0), MSB first. Received bytes go into a 4-entry RX FIFO. A single TX holding register supplies the byte shifted out on MISO. The SPI pins are asynchronous to `clk` and are oversampled.

---
 rtl/tqvp_spi_target_pkg.sv | 22 ++
 rtl/tqvp_spi_rx_fifo.sv | 52 +++++
 rtl/tqvp_spi_target.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tqvp_spi_target_pkg.sv
// Shared constants for the TinyQV SPI target: register map, status bit
// positions and default parameters.
package tqvp_spi_target_pkg;

  typedef logic [7:0] spi_byte_t;

  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_TX     = 4'd1;
  localparam logic [3:0] ADDR_RX     = 4'd2;
  localparam logic [3:0] ADDR_CONFIG = 4'd3;

  localparam int ST_RX_NE     = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_CS_ACTIVE = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_UNDERRUN  = 5;

  localparam int        RX_DEPTH_DEF  = 4;
  localparam spi_byte_t IDLE_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/tqvp_spi_rx_fifo.sv
// Receive FIFO for the SPI target. A pop in the same cycle as a push makes
// room when full; flush wins over both.
module tqvp_spi_rx_fifo
  import tqvp_spi_target_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      i_push,
  input  logic      i_pop,
  input  logic      i_flush,
  input  spi_byte_t i_data,
  output logic      o_full,
  output logic      o_empty,
  output spi_byte_t o_head
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  spi_byte_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == C_FULL);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // Storage needs no reset: the head is only exposed when the count is non-zero.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/tqvp_spi_target.sv
// SPI mode-0 target on the TinyQV peripheral bus: oversampled pins, shift
// registers, TX holding register, RX FIFO and the CPU register file.
module tqvp_spi_target
  import tqvp_spi_target_pkg::*;
#(
  parameter int        RX_DEPTH  = RX_DEPTH_DEF,
  parameter spi_byte_t IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic       data_read,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq
);

  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2;

  logic      r_enable;
  spi_byte_t r_tx_reg;
  logic      r_tx_empty;
  logic      r_overrun;
  logic      r_underrun;
  spi_byte_t r_tx_shift;
  logic [6:0] r_rx_shift;
  logic [2:0] r_bit_cnt;

  logic      w_active, w_cs_fall, w_sck_rise, w_sck_fall;
  logic      w_tx_load, w_push_req, w_pop, w_drop;
  logic      w_wr_status, w_wr_tx, w_wr_cfg;
  logic      w_full, w_empty;
  spi_byte_t w_head, w_rx_byte, w_status;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      {r_sck_s1, r_sck_s2, r_sck_s3} <= 3'b000;
      {r_cs_s1, r_cs_s2, r_cs_s3}    <= 3'b111;
      {r_mosi_s1, r_mosi_s2}         <= 2'b00;
    end else begin
      {r_sck_s1, r_sck_s2, r_sck_s3} <= {spi_sck, r_sck_s1, r_sck_s2};
      {r_cs_s1, r_cs_s2, r_cs_s3}    <= {spi_cs_n, r_cs_s1, r_cs_s2};
      {r_mosi_s1, r_mosi_s2}         <= {spi_mosi, r_mosi_s1};
    end
  end

  assign w_active   = r_enable & ~r_cs_s2;
  assign w_cs_fall  = r_enable & r_cs_s3 & ~r_cs_s2;
  assign w_sck_rise = w_active & r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall = w_active & ~r_sck_s2 & r_sck_s3;
  // A zero count on a falling edge means the previous byte just completed.
  assign w_tx_load  = w_cs_fall | (w_sck_fall & (r_bit_cnt == 3'd0));
  assign w_push_req = w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_rx_byte  = {r_rx_shift, r_mosi_s2};

  assign w_wr_status = data_write & (address == ADDR_STATUS);
  assign w_wr_tx     = data_write & (address == ADDR_TX);
  assign w_wr_cfg    = data_write & (address == ADDR_CONFIG);
  assign w_pop       = data_read & (address == ADDR_RX) & ~w_empty;
  assign w_drop      = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
    end else begin
      if (!w_active) begin
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= '0;
      end else if (w_sck_rise) begin
        r_rx_shift <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
      if (w_tx_load)       r_tx_shift <= r_tx_empty ? IDLE_BYTE : r_tx_reg;
      else if (w_sck_fall) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
    end
  end

  // A CPU write to TX lands after the load, so it wins over the load's tx_empty set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_enable   <= 1'b0;
      r_tx_reg   <= '0;
      r_tx_empty <= 1'b1;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_tx_load) r_tx_empty <= 1'b1;
      if (w_wr_tx) begin
        r_tx_reg   <= data_in;
        r_tx_empty <= 1'b0;
      end
      if (w_wr_cfg) r_enable <= data_in[0];
      r_overrun  <= (r_overrun & ~(w_wr_status & data_in[ST_OVERRUN])) | w_drop;
      r_underrun <= (r_underrun & ~(w_wr_status & data_in[ST_UNDERRUN])) |
                    (w_tx_load & r_tx_empty);
    end
  end

  tqvp_spi_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_flush (~r_enable),
    .i_data  (w_rx_byte),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_comb begin
    w_status               = 8'h00;
    w_status[ST_RX_NE]     = ~w_empty;
    w_status[ST_RX_FULL]   = w_full;
    w_status[ST_TX_EMPTY]  = r_tx_empty;
    w_status[ST_CS_ACTIVE] = ~r_cs_s2;
    w_status[ST_OVERRUN]   = r_overrun;
    w_status[ST_UNDERRUN]  = r_underrun;
    data_out = 8'h00;
    case (address)
      ADDR_STATUS: data_out = w_status;
      ADDR_TX:     data_out = r_tx_reg;
      ADDR_RX:     data_out = w_empty ? 8'h00 : w_head;
      ADDR_CONFIG: data_out = {7'd0, r_enable};
      default:     data_out = 8'h00;
    endcase
  end

  assign spi_miso    = r_tx_shift[7];
  assign spi_miso_oe = w_active;
  assign irq         = r_enable & (~w_empty | r_overrun);

endmodule
